// File: rtl/mac_feed_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mac_feed_sequencer
// Purpose : Fill/drain sequencer feeding a systolically skewed row of MACs.
// Rev     : 1.0  initial release
// ============================================================================
module mac_feed_sequencer #(
    parameter int NUM_FIFOS    = 9,
    parameter int DEPTH        = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int FILL_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    output logic                 fill,
    output logic [31:0]          fill_addr,
    input  logic [NUM_FIFOS-1:0] fifo_full,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    output logic [NUM_FIFOS-1:0] fifo_rd_en,
    output logic                 mac_clr,
    output logic [NUM_FIFOS-2:0] mac_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int C_NUM_ROWS = NUM_FIFOS - 1;
    localparam int C_LAST_T   = DEPTH + NUM_FIFOS - 2;
    localparam int C_TW       = $clog2(DEPTH + NUM_FIFOS);
    localparam int C_CW       = $clog2(FILL_TIMEOUT) + 1;

    generate
        if (DATA_WIDTH < 1 || DEPTH < 1 || NUM_FIFOS < 2 || FILL_TIMEOUT < 2) begin : g_bad_params
            $error("mac_feed_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [C_TW-1:0]       r_t;
    logic [C_TW-1:0]       w_next_t;
    logic [C_CW-1:0]       r_cnt;
    logic [C_CW-1:0]       w_next_cnt;
    logic                  w_accept;
    logic                  w_underflow;
    logic [31:0]           w_t_ext;
    logic [NUM_FIFOS-1:0]  w_next_rd;
    logic [NUM_FIFOS-1:0]  r_rd_en;
    logic [C_NUM_ROWS-1:0] r_mac_en;
    logic [31:0]           r_addr;
    logic                  r_fill;
    logic                  r_clr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    assign w_underflow = |(r_rd_en & fifo_empty);

    always_comb begin
        w_next_state = r_state;
        w_next_t     = r_t;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_CLR;
                end
            end
            S_CLR: begin
                w_next_cnt   = '0;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // A complete fill takes priority over a coincident timeout
                if (&fifo_full) begin
                    w_next_t     = '0;
                    w_next_state = S_DRAIN;
                end else if (r_cnt == C_CW'(FILL_TIMEOUT - 1)) begin
                    w_next_state = S_ERR;
                end else begin
                    w_next_cnt = r_cnt + C_CW'(1);
                end
            end
            S_DRAIN: begin
                if (w_underflow) begin
                    w_next_state = S_ERR;
                end else if (r_t == C_TW'(C_LAST_T)) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_t = r_t + C_TW'(1);
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_t_ext = 32'(w_next_t);

    // Read windows for the upcoming cycle: row k lags the vector FIFO by k
    always_comb begin
        w_next_rd = '0;
        if (w_next_state == S_DRAIN) begin
            for (int k = 0; k < C_NUM_ROWS; k++) begin
                w_next_rd[k] = (w_t_ext >= 32'(k)) && (w_t_ext < 32'(k + DEPTH));
            end
            w_next_rd[C_NUM_ROWS] = (w_t_ext < 32'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_t      <= '0;
            r_cnt    <= '0;
            r_rd_en  <= '0;
            r_mac_en <= '0;
            r_addr   <= '0;
            r_fill   <= 1'b0;
            r_clr    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_t     <= w_next_t;
            r_cnt   <= w_next_cnt;
            r_rd_en <= w_next_rd;
            // mac_en trails rd_en by the FIFO read latency; leaving DRAIN drops it
            r_mac_en <= (w_next_state == S_DRAIN) ? r_rd_en[C_NUM_ROWS-1:0] : '0;
            if (w_accept) begin
                r_addr <= base_addr;
            end
            r_fill <= (w_next_state == S_CLR);
            r_clr  <= (w_next_state == S_CLR);
            r_busy <= (w_next_state == S_CLR) || (w_next_state == S_WAIT) ||
                      (w_next_state == S_DRAIN) || (w_next_state == S_DONE);
            r_done <= (w_next_state == S_DONE);
            r_err  <= (w_next_state == S_ERR);
        end
    end

    assign fill       = r_fill;
    assign fill_addr  = r_addr;
    assign fifo_rd_en = r_rd_en;
    assign mac_clr    = r_clr;
    assign mac_en     = r_mac_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: doc/mac_feed_sequencer.md
Name: mac_feed_sequencer

Overview:
Top-level sequencer for the matrix-vector MAC datapath. On `start` it pulses `fill` to the memory feeder and waits until all `NUM_FIFOS` FIFOs are full. It then drains them with a systolic skew: row FIFO k starts k cycles after the vector FIFO. It drives per-MAC enables and reports `done`, or an error on fill timeout or FIFO underflow.

Parameters:
NUM_FIFOS, 9, total FIFOs; indices 0..NUM_FIFOS-2 are matrix rows (one per MAC), index NUM_FIFOS-1 is the vector FIFO
DEPTH, 8, entries per FIFO (elements per row)
DATA_WIDTH, 8, element width (no datapath here; kept for integration consistency)
FILL_TIMEOUT, 1024, max cycles in WAIT before error

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation; honoured only in IDLE or ERR
base_addr  in  32  memory address for the feeder, latched on accepted start
fill  out  1  one-cycle pulse to feeder
fill_addr  out  32  latched base_addr, held stable until next accepted start
fifo_full  in  NUM_FIFOS  per-FIFO full flags
fifo_empty  in  NUM_FIFOS  per-FIFO empty flags
fifo_rd_en  out  NUM_FIFOS  per-FIFO read enables (1-cycle read latency downstream)
mac_clr  out  1  one-cycle accumulator clear
mac_en  out  NUM_FIFOS-1  per-MAC accumulate enable
busy  out  1  high in CLR, WAIT, DRAIN, DONE
done  out  1  one-cycle completion pulse
err  out  1  high while in ERR

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, fill_addr=0, all counters 0, mac_en pipeline cleared. Applies mid-operation with no completion pulse.
- States: IDLE, CLR, WAIT, DRAIN, DONE, ERR.
- IDLE:
  - start=1 -> latch base_addr into fill_addr, go to CLR.
  - start=0 -> stay.
- CLR: mac_clr=1 and fill=1 for exactly this cycle; timeout counter cleared; -> WAIT.
- WAIT:
  - &fifo_full=1 -> DRAIN with drain counter t=0.
  - Otherwise the timeout counter increments; on reaching FILL_TIMEOUT-1 -> ERR.
  - If full and timeout coincide, full wins.
- DRAIN: t counts 0..DEPTH+NUM_FIFOS-2 inclusive; 16 cycles at defaults.
  - Vector FIFO read: fifo_rd_en[NUM_FIFOS-1] = (t < DEPTH).
  - Row k read: fifo_rd_en[k] = (k <= t < k+DEPTH), for k=0..NUM_FIFOS-2.
  - mac_en[k] = fifo_rd_en[k] registered one cycle; it is the only registered lag, matching FIFO read latency.
  - Final cycle (t=DEPTH+NUM_FIFOS-2): no rd_en, last mac_en fires; -> DONE.
  - rd_en[i]=1 while fifo_empty[i]=1 -> ERR on the next edge. The rd_en outputs are 0 from that edge on; in-flight mac_en is dropped.
- DONE: done=1 for one cycle; -> IDLE. start during DONE is ignored.
- ERR:
  - err=1, busy=0, all enables 0.
  - start=1 -> relatch base_addr, err drops, -> CLR.
- Drain counter width: $clog2(DEPTH+NUM_FIFOS). Timeout counter width: $clog2(FILL_TIMEOUT)+1. No wrap in either; both are cleared on state entry.
- fill is never asserted outside CLR. rd_en and mac_en are never asserted outside DRAIN, except the registered mac_en tail within DRAIN's last cycle.

Test Plan:
- Nominal: reset, base_addr=0x100, start pulse.
  - Expect fill=1 one cycle after start and fill_addr=0x100.
  - Assert all fifo_full 5 cycles later.
  - fifo_rd_en[8] high DRAIN cycles 0-7; fifo_rd_en[0] 0-7; fifo_rd_en[7] 7-14.
  - mac_en[7] high cycles 8-15; done pulses once; total DRAIN = 16 cycles.
- Timeout: start, never assert fifo_full -> err=1 exactly FILL_TIMEOUT cycles after entering WAIT. Then start with base_addr=0x200 -> err=0, fill pulses, fill_addr=0x200.
- Underflow: during DRAIN t=3, force fifo_empty[2]=1 with rd_en[2] high. Expect ERR next cycle, all rd_en/mac_en 0, no done.
- Start while busy: pulse start with base_addr=0x300 during WAIT and again in DONE. Expect fill_addr unchanged and no extra fill pulse.
- Async reset mid-DRAIN at t=5: all outputs 0 immediately (before the next clk edge), fill_addr=0, state IDLE. After release, a new start gives the nominal sequence.
- Full and timeout same cycle: assert &fifo_full on the cycle the timeout counter reaches FILL_TIMEOUT-1 -> DRAIN entered, err stays 0.
